// File: rtl/pushb_debounce.sv
// Pushbutton conditioner: per-channel synchroniser, stability-counter debounce,
// and registered one-cycle press/release strobes, all in the clk_ext domain.
module pushb_debounce #(
  parameter int NUM_SW          = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk_ext,
  input  logic              rst_extn,
  input  logic [NUM_SW-1:0] pushb_sw_raw,
  output logic [NUM_SW-1:0] pushb_sw,
  output logic [NUM_SW-1:0] pushb_press,
  output logic [NUM_SW-1:0] pushb_release
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0] sync;

  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [NUM_SW-1:0] press_q, press_d;
  logic [NUM_SW-1:0] release_q, release_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];
  logic [CNT_W-1:0]  cnt_d [NUM_SW];

  // Plain flop chain: nothing may sit between stages or metastability margin is lost.
  always_ff @(posedge clk_ext) begin
    if (!rst_extn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pushb_sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Accept the new level; the strobe registers on the same edge as the level.
          stable_d[i]  = sync[i];
          press_d[i]   = sync[i];
          release_d[i] = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_ext) begin
    if (!rst_extn) begin
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
    end else begin
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pushb_sw      = stable_q;
  assign pushb_press   = press_q;
  assign pushb_release = release_q;

endmodule

// File: tb/tb_pushb_debounce.sv
// Scoreboard bench for pushb_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=16):
// stimulus queues expected strobe events, a negedge monitor pops and compares them.
module tb_pushb_debounce;

  localparam int NUM_SW = 5;
  localparam int SYNC   = 2;
  localparam int DEB    = 16;
  // Inputs change at a negedge after edge count N; strobe is visible at the negedge after edge N+1+SYNC-1+DEB.
  localparam int LAT    = SYNC + DEB;

  typedef struct {
    int              at;
    logic [NUM_SW-1:0] press;
    logic [NUM_SW-1:0] rel;
    logic [NUM_SW-1:0] sw;
  } ev_t;

  logic              clk_ext = 1'b0;
  logic              rst_extn;
  logic [NUM_SW-1:0] pushb_sw_raw;
  logic [NUM_SW-1:0] pushb_sw, pushb_press, pushb_release;

  int  edge_n = 0;
  int  n_vec  = 0;
  int  n_err  = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];
  logic [NUM_SW-1:0] sw_model = '0;

  pushb_debounce #(
    .NUM_SW(NUM_SW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_ext(clk_ext), .rst_extn(rst_extn), .pushb_sw_raw(pushb_sw_raw),
    .pushb_sw(pushb_sw), .pushb_press(pushb_press), .pushb_release(pushb_release)
  );

  always #5 clk_ext = ~clk_ext;
  always @(posedge clk_ext) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_ext);
  endtask

  // Queue an accepted transition that takes effect LAT edges from now.
  task automatic expect_ev(input logic [NUM_SW-1:0] press, input logic [NUM_SW-1:0] rel);
    ev_t e;
    sw_model = (sw_model | press) & ~rel;
    e.at = edge_n + LAT; e.press = press; e.rel = rel; e.sw = sw_model;
    exp_q.push_back(e);
  endtask

  // Monitor: any strobe must match the head of the scoreboard at the exact edge.
  always @(negedge clk_ext) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
        chk("missed_strobe_at", 32'(exp_q[0].at), 32'(-1));
        void'(exp_q.pop_front());
      end
      if (pushb_press !== '0 || pushb_release !== '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {pushb_press, pushb_release}, '0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("strobe_edge", 32'(edge_n), 32'(e.at));
          chk("press",       32'(pushb_press),   32'(e.press));
          chk("release",     32'(pushb_release), 32'(e.rel));
          chk("level",       32'(pushb_sw),      32'(e.sw));
        end
      end
    end
  end

  initial begin
    int t;
    rst_extn     = 1'b0;
    pushb_sw_raw = '1;

    // Reset held 3 cycles with all buttons down: everything stays clear.
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("rst_sw",      32'(pushb_sw),      0);
      chk("rst_press",   32'(pushb_press),   0);
      chk("rst_release", 32'(pushb_release), 0);
    end
    mon_en   = 1'b1;
    rst_extn = 1'b1;
    expect_ev(5'h1F, 5'h00);
    cyc(25);
    chk("lvl_after_reset", 32'(pushb_sw), 32'h1F);

    pushb_sw_raw = '0;
    expect_ev(5'h00, 5'h1F);
    cyc(25);
    chk("lvl_all_released", 32'(pushb_sw), 0);

    // Clean press, hold 40 cycles, release on bit 0.
    pushb_sw_raw[0] = 1'b1;
    expect_ev(5'h01, 5'h00);
    cyc(40);
    chk("lvl_bit0_held", 32'(pushb_sw), 32'h01);
    pushb_sw_raw[0] = 1'b0;
    expect_ev(5'h00, 5'h01);
    cyc(25);
    chk("lvl_bit0_released", 32'(pushb_sw), 0);

    // Bounce on bit 2: 3-cycle segments never reach acceptance.
    for (int k = 0; k < 10; k++) begin
      pushb_sw_raw[2] = (k % 2 == 0);
      cyc(3);
      chk("lvl_bouncing", 32'(pushb_sw[2]), 0);
    end
    pushb_sw_raw[2] = 1'b1;
    expect_ev(5'h04, 5'h00);
    cyc(25);
    chk("lvl_bit2_settled", 32'(pushb_sw), 32'h04);

    // Glitch on bit 1 one cycle before acceptance restarts the count.
    pushb_sw_raw[1] = 1'b1;
    cyc(15);
    pushb_sw_raw[1] = 1'b0;
    cyc(1);
    chk("lvl_bit1_glitch", 32'(pushb_sw[1]), 0);
    pushb_sw_raw[1] = 1'b1;
    expect_ev(5'h02, 5'h00);
    cyc(25);
    chk("lvl_bit1_settled", 32'(pushb_sw), 32'h06);

    // Bits 3 and 4 rise together.
    pushb_sw_raw[4:3] = 2'b11;
    expect_ev(5'h18, 5'h00);
    cyc(25);
    chk("lvl_bits34", 32'(pushb_sw), 32'h1E);

    pushb_sw_raw = '0;
    expect_ev(5'h00, 5'h1E);
    cyc(25);
    chk("lvl_cleared", 32'(pushb_sw), 0);

    // Reset mid-count on bit 0: the pending acceptance is discarded.
    pushb_sw_raw[0] = 1'b1;
    cyc(10);
    rst_extn = 1'b0;
    cyc(2);
    chk("midrst_sw",    32'(pushb_sw),    0);
    chk("midrst_press", 32'(pushb_press), 0);
    rst_extn = 1'b1;
    expect_ev(5'h01, 5'h00);
    cyc(25);
    chk("lvl_after_midrst", 32'(pushb_sw), 32'h01);

    pushb_sw_raw[0] = 1'b0;
    expect_ev(5'h00, 5'h01);

    // Drain the scoreboard with a bounded wait.
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      cyc(1);
      t++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
